// File: rtl/processor_scheduler.sv
// Round-robin scheduler sharing one processor divider between N_CH channels.
// Grants a channel, issues its operands, waits for valid (with timeout), and returns the result.
module processor_scheduler #(
  parameter int N_CH      = 4,
  parameter int DATA_SIZE = 14,
  parameter int TIMEOUT   = 64
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH*DATA_SIZE-1:0] i_reference,
  input  logic [N_CH*DATA_SIZE-1:0] i_error,
  output logic [N_CH-1:0]           o_ack,
  output logic [DATA_SIZE-1:0]      o_proc_reference,
  output logic [DATA_SIZE-1:0]      o_proc_error,
  output logic                      o_proc_start,
  input  logic [DATA_SIZE-1:0]      i_proc_quotient,
  input  logic [DATA_SIZE-1:0]      i_proc_remainder,
  input  logic                      i_proc_valid,
  output logic [DATA_SIZE-1:0]      o_quotient,
  output logic [DATA_SIZE-1:0]      o_remainder,
  output logic [N_CH-1:0]           o_done,
  output logic                      o_timeout,
  output logic                      o_busy
);

  localparam int PTR_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0]      ack_q, ack_d;
  logic                 start_q, start_d;
  logic [DATA_SIZE-1:0] pref_q, pref_d;
  logic [DATA_SIZE-1:0] perr_q, perr_d;
  logic [DATA_SIZE-1:0] quot_q, quot_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [N_CH-1:0]      done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic [DATA_SIZE-1:0] ref_arr [N_CH];
  logic [DATA_SIZE-1:0] err_arr [N_CH];
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ref_arr[k] = i_reference[k*DATA_SIZE +: DATA_SIZE];
      err_arr[k] = i_error[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % N_CH);
      if (i_req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    start_d   = 1'b0;
    pref_d    = pref_q;
    perr_d    = perr_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    done_d    = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          ch_d     = grant_idx;
          pref_d   = ref_arr[grant_idx];
          perr_d   = err_arr[grant_idx];
          ack_d    = N_CH'(1) << grant_idx;
          start_d  = 1'b1;
          rr_ptr_d = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A stale or stuck valid from the processor is deliberately not looked at here.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_proc_valid) begin
          quot_d  = i_proc_quotient;
          rem_d   = i_proc_remainder;
          done_d  = N_CH'(1) << ch_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          quot_d    = '1;
          rem_d     = '0;
          done_d    = N_CH'(1) << ch_q;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      start_q   <= 1'b0;
      pref_q    <= '0;
      perr_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      pref_q    <= pref_d;
      perr_q    <= perr_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_ack            = ack_q;
  assign o_proc_start     = start_q;
  assign o_proc_reference = pref_q;
  assign o_proc_error     = perr_q;
  assign o_quotient       = quot_q;
  assign o_remainder      = rem_q;
  assign o_done           = done_q;
  assign o_timeout        = timeout_q;
  assign o_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_processor_scheduler.sv
// Bench for processor_scheduler: a job-timeline model checked every cycle,
// plus directed scenarios with hand-computed cycle numbers and results.
module tb_processor_scheduler;

  localparam int N  = 4;
  localparam int DS = 14;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DS-1:0] refv = '0;
  logic [N*DS-1:0] errv = '0;
  logic [N-1:0]    o_ack, o_done;
  logic [DS-1:0]   o_pref, o_perr, o_q, o_r;
  logic            o_start, o_to, o_busy;
  logic [DS-1:0]   pq = '0, pr = '0;
  logic            pvalid = 1'b0;

  processor_scheduler #(.N_CH(N), .DATA_SIZE(DS), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_req(req),
    .i_reference(refv), .i_error(errv),
    .o_ack(o_ack), .o_proc_reference(o_pref), .o_proc_error(o_perr),
    .o_proc_start(o_start), .i_proc_quotient(pq), .i_proc_remainder(pr),
    .i_proc_valid(pvalid), .o_quotient(o_q), .o_remainder(o_r),
    .o_done(o_done), .o_timeout(o_to), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a job is described by its channel and its age in cycles since grant.
  bit          m_job = 0;
  int          m_ch = 0, m_age = 0, m_ptr = 0;
  logic [N-1:0]  e_ack = '0, e_done = '0;
  logic          e_start = 0, e_to = 0;
  logic [DS-1:0] e_pref = '0, e_perr = '0, e_q = '0, e_r = '0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_job <= 0; m_ch <= 0; m_age <= 0; m_ptr <= 0;
      e_ack <= '0; e_done <= '0; e_start <= 0; e_to <= 0;
      e_pref <= '0; e_perr <= '0; e_q <= '0; e_r <= '0;
    end else begin
      e_ack <= '0; e_start <= 0; e_done <= '0; e_to <= 0;
      if (!m_job) begin
        if (req != 0) begin
          m_job   <= 1;
          m_ch    <= pick(req, m_ptr);
          m_age   <= 1;
          m_ptr   <= (pick(req, m_ptr) + 1) % N;
          e_ack   <= N'(1) << pick(req, m_ptr);
          e_start <= 1;
          e_pref  <= refv[pick(req, m_ptr)*DS +: DS];
          e_perr  <= errv[pick(req, m_ptr)*DS +: DS];
        end
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (pvalid) begin
        e_q <= pq; e_r <= pr; e_done <= N'(1) << m_ch; m_job <= 0;
      end else if (m_age - 2 == TO - 1) begin
        e_q <= '1; e_r <= '0; e_done <= N'(1) << m_ch; e_to <= 1; m_job <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_ack", o_ack, e_ack);
    check("cmp_start", o_start, e_start);
    check("cmp_busy", o_busy, m_job);
    check("cmp_pref", o_pref, e_pref);
    check("cmp_perr", o_perr, e_perr);
    check("cmp_done", o_done, e_done);
    check("cmp_timeout", o_to, e_to);
    check("cmp_quotient", o_q, e_q);
    check("cmp_remainder", o_r, e_r);
  end

  // Event log and processor responder, all advanced from one step task.
  int grants[$];
  int done_chs[$];
  int ack_cyc = 0, done_cyc = 0, done_cnt = 0, t_req = 0;
  int last_ch = -1, last_to = 0;
  int last_q = 0, last_r = 0;
  int pm_cnt = 0, pm_delay = 1;
  bit pm_never = 0, pm_stuck = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (o_ack[k]) begin
        req[k] = 1'b0;
        grants.push_back(k);
        ack_cyc = cyc;
      end
      if (o_done[k]) begin
        last_ch = k;
        done_chs.push_back(k);
      end
    end
    if (o_done != 0) begin
      done_cnt++;
      done_cyc = cyc;
      last_to  = o_to;
      last_q   = o_q;
      last_r   = o_r;
    end
    pvalid = pm_stuck;
    if (!rst_n) pm_cnt = 0;
    if (pm_cnt > 0) begin
      pm_cnt--;
      if (pm_cnt == 0 && !pm_never) pvalid = 1'b1;
    end
    if (o_start) pm_cnt = pm_delay;
  endtask

  task automatic wait_done(input string name, input int bound);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < bound) begin
      step();
      n++;
    end
    check(name, done_cnt > start_cnt, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int k, input logic [DS-1:0] r, input logic [DS-1:0] e);
    refv[k*DS +: DS] = r;
    errv[k*DS +: DS] = e;
  endtask

  initial begin
    int base;
    repeat (3) step();
    check("rst_busy", o_busy, 0);
    check("rst_quotient", o_q, 0);
    rst_n = 1'b1;
    step();

    // Single request on ch0.
    set_ops(0, 14'h1030, 14'h2FF8);
    pq = 14'h0123; pr = 14'h0045; pm_delay = 5;
    req[0] = 1'b1; t_req = cyc;
    wait_done("t1_done_seen", 20);
    check("t1_ack_cycle", ack_cyc - t_req, 1);
    check("t1_done_cycle", done_cyc - t_req, 7);
    check("t1_done_ch", last_ch, 0);
    check("t1_quotient", last_q, 14'h0123);
    check("t1_remainder", last_r, 14'h0045);
    check("t1_timeout", last_to, 0);

    // Round robin from a fresh reset.
    do_reset();
    for (int k = 0; k < N; k++) set_ops(k, DS'(14'h100 + k), DS'(14'h200 + k));
    pq = 14'h0011; pr = 14'h0022; pm_delay = 2;
    grants.delete();
    req = 4'b1111;
    for (int j = 0; j < 4; j++) wait_done("t2_done_seen", 20);
    req = 4'b0101;
    for (int j = 0; j < 2; j++) wait_done("t2b_done_seen", 20);
    check("t2_grant_count", grants.size(), 6);
    if (grants.size() == 6) begin
      for (int j = 0; j < 4; j++) check("t2_order", grants[j], j);
      check("t2_second_0", grants[4], 0);
      check("t2_second_2", grants[5], 2);
    end

    // Timeout on ch1 (pointer is at 3), then a normal job on ch3.
    pm_never = 1;
    req[1] = 1'b1; t_req = cyc;
    wait_done("t3_done_seen", 80);
    check("t3_done_cycle", done_cyc - t_req, 66);
    check("t3_done_ch", last_ch, 1);
    check("t3_timeout", last_to, 1);
    check("t3_quotient", last_q, 14'h3FFF);
    check("t3_remainder", last_r, 0);
    pm_never = 0; pm_delay = 3;
    req[3] = 1'b1;
    wait_done("t3b_done_seen", 20);
    check("t3b_done_ch", last_ch, 3);
    check("t3b_timeout", last_to, 0);
    check("t3b_quotient", last_q, 14'h0011);

    // Valid arrives on the last WAIT cycle before the timeout would fire.
    pq = 14'h0ABC; pr = 14'h0012; pm_delay = TO;
    req[2] = 1'b1; t_req = cyc;
    wait_done("t4_done_seen", 80);
    check("t4_done_cycle", done_cyc - t_req, 66);
    check("t4_done_ch", last_ch, 2);
    check("t4_timeout", last_to, 0);
    check("t4_quotient", last_q, 14'h0ABC);
    check("t4_remainder", last_r, 14'h0012);

    // Stuck-high valid, ch1 and ch3 alternating (pointer is at 3).
    pm_stuck = 1;
    done_chs.delete();
    req = 4'b1010; t_req = cyc;
    wait_done("t5_done_seen", 20);
    check("t5_first_done_cycle", done_cyc - t_req, 3);
    wait_done("t5_done_seen", 20);
    req = 4'b1010;
    wait_done("t5_done_seen", 20);
    wait_done("t5_done_seen", 20);
    check("t5_done_count", done_chs.size(), 4);
    if (done_chs.size() == 4) begin
      check("t5_seq0", done_chs[0], 3);
      check("t5_seq1", done_chs[1], 1);
      check("t5_seq2", done_chs[2], 3);
      check("t5_seq3", done_chs[3], 1);
    end

    // Reset during WAIT of a ch2 job with ch1 pending.
    pm_stuck = 0; pm_never = 1; pvalid = 1'b0;
    req[2] = 1'b1;
    repeat (4) step();
    req[1] = 1'b1;
    step();
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", o_ack, 0);
    check("t6_rst_done", o_done, 0);
    check("t6_rst_start", o_start, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_q", o_q, 0);
    check("t6_rst_pref", o_pref, 0);
    pm_never = 0; pm_delay = 2;
    grants.delete();
    repeat (2) step();
    rst_n = 1'b1;
    wait_done("t6_done_seen", 20);
    check("t6_done_count", done_cnt - base, 1);
    check("t6_done_ch", last_ch, 1);
    check("t6_grant_count", grants.size(), 1);
    if (grants.size() >= 1) check("t6_first_grant", grants[0], 1);
    repeat (10) step();
    check("t6_no_regrant", grants.size(), 1);
    req[2] = 1'b1;
    wait_done("t6b_done_seen", 20);
    check("t6b_done_ch", last_ch, 2);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_scheduler.md
# processor_scheduler

Round-robin scheduler that shares one `processor` divider instance between `N_CH` requesting channels. Each channel presents a reference/error operand pair. The scheduler grants one channel, drives the processor's operands and start, waits for the processor's valid (bounded by a timeout), and returns the quotient/remainder to the granted channel. It sits between the per-channel gain-control loops and the single `processor` datapath.

## Interface
Parameters:
- `N_CH`, default 4: number of requesting channels (2..8).
- `DATA_SIZE`, default 14: operand and result width; must match `processor.DATA_SIZE`.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before a job is aborted (≥2).

Ports:
- `i_clock` in 1: system clock; all state is on its rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_req` in `N_CH`: per-channel request level; held until that channel's `o_ack`, dropped the cycle after.
- `i_reference` in `N_CH*DATA_SIZE`: channel k at `[k*DATA_SIZE +: DATA_SIZE]`.
- `i_error` in `N_CH*DATA_SIZE`: same packing as `i_reference`.
- `o_ack` out `N_CH`: one-hot, one-cycle pulse; operands of that channel have been captured.
- `o_proc_reference` out `DATA_SIZE`: to `processor.i_reference`; held stable from start until the job ends.
- `o_proc_error` out `DATA_SIZE`: to `processor.i_error`; held stable likewise.
- `o_proc_start` out 1: to `processor.i_start`; one-cycle pulse.
- `i_proc_quotient` in `DATA_SIZE`, `i_proc_remainder` in `DATA_SIZE`: from the processor.
- `i_proc_valid` in 1: from the processor.
- `o_quotient` out `DATA_SIZE`, `o_remainder` out `DATA_SIZE`: result of the last job; held until the next job completes.
- `o_done` out `N_CH`: one-hot, one-cycle pulse identifying the channel whose result is on `o_quotient`/`o_remainder`.
- `o_timeout` out 1: one-cycle pulse, coincident with `o_done`, when a job is aborted.
- `o_busy` out 1: high in ISSUE and WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any `i_req` bit is set, choose channel k = first set bit searching upward (with wrap) from `rr_ptr`.
  - Register that channel's operands into `o_proc_*`, set `o_ack[k]` and `o_proc_start`, set `rr_ptr <= (k+1) mod N_CH`, go to ISSUE.
  - Otherwise remain in IDLE.
- **ISSUE (1 cycle):**
  - Clear `o_ack` and `o_proc_start`, clear the timeout counter, go to WAIT.
  - `i_proc_valid` is ignored in this cycle, which covers processors whose valid is stale or stuck high.
- **WAIT:**
  - If `i_proc_valid` is high: register `i_proc_quotient`/`i_proc_remainder`, pulse `o_done[k]`, go to IDLE.
  - Else if counter == `TIMEOUT-1`: set `o_quotient` to all ones and `o_remainder` to 0, pulse `o_done[k]` and `o_timeout`, go to IDLE.
  - Else increment the counter.
  - If valid and the timeout condition occur in the same cycle, valid wins and `o_timeout` stays 0.
- Requests arriving during ISSUE/WAIT wait; there is no queueing beyond the `i_req` levels.
- Counter width is `$clog2(TIMEOUT)`; no wrap is possible because the counter is cleared in ISSUE.

## Timing
- Reset (`i_reset`=0, asynchronous):
  - state IDLE, `rr_ptr`=0, counter=0.
  - All outputs 0: `o_ack`, `o_done`, `o_proc_start`, `o_timeout`, `o_busy`, `o_quotient`, `o_remainder`, `o_proc_reference`, `o_proc_error`.
- Reset mid-job aborts the job with no `o_done`. After release, pending requests are arbitrated from `rr_ptr`=0.
- Latency, cycle numbers relative to the edge that samples `i_req` in IDLE (cycle 0):
  - `o_ack`/`o_proc_start`/`o_busy` high in cycle 1.
  - First WAIT cycle is cycle 2.
  - `o_done` appears the cycle after the WAIT cycle that sees valid, so the minimum is cycle 3.
- Timeout: the `o_done`/`o_timeout` pulse appears `TIMEOUT` cycles after entering WAIT, i.e. at cycle 2+`TIMEOUT`.
- The next grant can be issued in the same cycle that `o_done` is high, because the FSM is already back in IDLE. Back-to-back period is 3 + (WAIT length − 1) cycles.
- `o_busy` falls in the `o_done` cycle.

## Test plan
1. **Single request:** ch0 requests with ref=0x1030, err=0x2FF8; processor model asserts valid 5 cycles after start with q=0x0123, r=0x0045. Required: `o_ack`=0001 and start at cycle 1; `o_proc_*`=0x1030/0x2FF8 held stable; `o_done`=0001 with q=0x0123, r=0x0045 one cycle after valid; `o_timeout`=0.
2. **Round robin:** all four channels request together after reset, each dropping its request after its ack. Required: grant order 0,1,2,3. Then ch2 and ch0 request together: ch0 is granted first (`rr_ptr`=0), then ch2.
3. **Timeout:** processor model never asserts valid, `TIMEOUT`=64. Required: `o_done[k]` and `o_timeout` pulse at cycle 66 with q=0x3FFF, r=0. A following request is then served normally.
4. **Valid at the timeout edge:** processor model asserts valid exactly on the counter==63 cycle. Required: normal completion with the model's q/r and `o_timeout`=0.
5. **Stuck valid:** `i_proc_valid` held at 1 constantly. Required: valid is ignored in ISSUE; completion in the first WAIT cycle (`o_done` at cycle 3); consecutive jobs alternate correctly between ch1 and ch3.
6. **Reset mid-job:** assert `i_reset`=0 during WAIT of a ch2 job while ch1 is pending. Required: all outputs 0 immediately and no `o_done` for ch2. After release, ch1 is acked first (search from 0); ch2 is re-served only if it re-requests.
